// File: rtl/sd_boot_loader_pkg.sv
// Shared types and constants for the SD boot loader: FSM encoding and sector geometry.
// Included by the loader top, its byte packer and the bus interface.
package sd_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_REQ      = 3'd2,
        ST_READ     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int SECTOR_BYTES     = 512;
    localparam int WORDS_PER_SECTOR = 128;
    localparam int BYTE_IDX_W       = 9;
    localparam int WORD_IDX_W       = 7;
    localparam int BYTE_CNT_W       = 10;
    localparam int LANES            = 4;

    // Word offset of the first word of a sector within the load (wraps mod 2^32).
    function automatic logic [31:0] sector_word_base(input logic [31:0] sec_idx);
        return sec_idx * 32'(WORDS_PER_SECTOR);
    endfunction

endpackage

// File: rtl/sd_boot_loader_if.sv
// Bus bundle between the boot loader, the SD sector reader and the target word memory.
// master = loader side, slave = reader/memory side.
interface sd_boot_loader_if
    import sd_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 16
) ();

    logic                  rstart;
    logic [31:0]           rsector;
    logic                  rbusy;
    logic                  rdone;
    logic                  outen;
    logic [BYTE_IDX_W-1:0] outaddr;
    logic [7:0]            outbyte;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output rstart, rsector, mem_we, mem_addr, mem_wdata,
        input  rbusy, rdone, outen, outaddr, outbyte
    );

    modport slave (
        input  rstart, rsector, mem_we, mem_addr, mem_wdata,
        output rbusy, rdone, outen, outaddr, outbyte
    );

endinterface

// File: rtl/sd_byte_packer.sv
// Packs the reader byte stream into little-endian 32-bit words and counts bytes per sector.
// word_valid is combinational in the cycle the lane-3 byte arrives; the caller registers it.
module sd_byte_packer
    import sd_boot_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  outen,
    input  logic [BYTE_IDX_W-1:0] outaddr,
    input  logic [7:0]            outbyte,
    output logic                  word_valid,
    output logic [WORD_IDX_W-1:0] word_idx,
    output logic [31:0]           word_data,
    output logic [BYTE_CNT_W-1:0] byte_cnt
);

    // Only lanes 0..2 are stored; lane 3 completes the word straight from outbyte.
    logic [8*(LANES-1)-1:0] pack_q, pack_d, pack_upd;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic                   take;

    assign take = en && outen;

    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
            assign pack_upd[8*gi +: 8] = (take && outaddr[1:0] == 2'(gi)) ? outbyte
                                                                          : pack_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        if (clr) begin
            pack_d     = '0;
            byte_cnt_d = '0;
        end else if (take) begin
            pack_d     = pack_upd;
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            pack_q     <= pack_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign word_valid = take && (outaddr[1:0] == 2'd3);
    assign word_idx   = outaddr[BYTE_IDX_W-1:2];
    assign word_data  = {outbyte, pack_q};
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: rtl/sd_boot_loader.sv
// Sequences multi-sector SD reads and streams the packed words into a word-addressed memory.
// Optional running checksum output is enabled by defining SD_BOOT_LOADER_CHECKSUM_EN.
module sd_boot_loader
    import sd_boot_loader_pkg::*;
#(
    parameter logic [31:0] START_SECTOR = 32'd0,
    parameter logic [31:0] NUM_SECTORS  = 32'd64,
    parameter int          ADDR_W       = 16,
    parameter int unsigned BASE_WADDR   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] sec_cnt,
`ifdef SD_BOOT_LOADER_CHECKSUM_EN
    output logic [31:0] csum,
`endif
    sd_boot_loader_if.master bus
);

    generate
        if (NUM_SECTORS == 32'd0) begin : g_bad_num_sectors
            $error("sd_boot_loader: NUM_SECTORS must be at least 1");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [31:0]         sec_idx_q, sec_idx_d;
    logic                error_q, error_d;
    logic                seen_low_q, seen_low_d;
    logic [31:0]         rsector_q, rsector_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                start_acc;
    logic                req_entry;
    logic [31:0]         addr_full;

    logic                  word_valid;
    logic [WORD_IDX_W-1:0] word_idx;
    logic [31:0]           word_data;
    logic [BYTE_CNT_W-1:0] byte_cnt;

    sd_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q == ST_READ),
        .clr        (req_entry),
        .outen      (bus.outen),
        .outaddr    (bus.outaddr),
        .outbyte    (bus.outbyte),
        .word_valid (word_valid),
        .word_idx   (word_idx),
        .word_data  (word_data),
        .byte_cnt   (byte_cnt)
    );

    always_comb begin
        state_d    = state_q;
        sec_idx_d  = sec_idx_q;
        error_d    = error_q;
        seen_low_d = seen_low_q;
        rsector_d  = rsector_q;
        start_acc  = 1'b0;
        req_entry  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    error_d   = 1'b0;
                    sec_idx_d = '0;
                    state_d   = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (!bus.rbusy) begin
                    state_d = ST_REQ;
                end
            end
            // rbusy may still be high from the previous sector; only a rise after a low cycle counts.
            ST_REQ: begin
                if (!bus.rbusy) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (bus.rdone) begin
                    if (byte_cnt != BYTE_CNT_W'(SECTOR_BYTES)) begin
                        error_d = 1'b1;
                    end
                    sec_idx_d = sec_idx_q + 32'd1;
                    state_d   = (sec_idx_d == NUM_SECTORS) ? ST_DONE : ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_REQ && state_q != ST_REQ) begin
            req_entry  = 1'b1;
            seen_low_d = 1'b0;
            rsector_d  = START_SECTOR + sec_idx_d;
        end
    end

    // Address uses sec_idx of the byte-arrival cycle, before any same-cycle rdone increment lands.
    always_comb begin
        mem_we_d    = word_valid;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        addr_full   = 32'(BASE_WADDR) + sector_word_base(sec_idx_q) + 32'(word_idx);
        if (word_valid) begin
            mem_addr_d  = ADDR_W'(addr_full);
            mem_wdata_d = word_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sec_idx_q   <= '0;
            error_q     <= 1'b0;
            seen_low_q  <= 1'b0;
            rsector_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sec_idx_q   <= sec_idx_d;
            error_q     <= error_d;
            seen_low_q  <= seen_low_d;
            rsector_q   <= rsector_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef SD_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_acc) begin
            csum_d = '0;
        end else if (mem_we_q) begin
            csum_d = csum_q + mem_wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

    assign busy          = (state_q == ST_WAIT_RDY) || (state_q == ST_REQ) || (state_q == ST_READ);
    assign done          = (state_q == ST_DONE);
    assign error         = error_q;
    assign sec_cnt       = sec_idx_q;
    assign bus.rstart    = (state_q == ST_REQ);
    assign bus.rsector   = rsector_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sd_boot_loader.sv
// Self-checking bench for sd_boot_loader: reader model, write scoreboard, load table, corner sequences.
module tb_sd_boot_loader;

    localparam logic [31:0] START_SECTOR = 32'd8;
    localparam logic [31:0] NUM_SECTORS  = 32'd3;
    localparam int          ADDR_W       = 16;
    localparam int unsigned BASE_WADDR   = 32'h0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, error;
    logic [31:0] sec_cnt;
`ifdef SD_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    sd_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    always #5 clk = ~clk;

    sd_boot_loader #(
        .START_SECTOR (START_SECTOR),
        .NUM_SECTORS  (NUM_SECTORS),
        .ADDR_W       (ADDR_W),
        .BASE_WADDR   (BASE_WADDR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .sec_cnt (sec_cnt),
`ifdef SD_BOOT_LOADER_CHECKSUM_EN
        .csum    (csum),
`endif
        .bus     (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        int                short_sec;
        int                short_len;
        int                start_at;
        logic              exp_error;
        int                exp_words;
        logic [ADDR_W-1:0] exp_first;
        logic [ADDR_W-1:0] exp_last;
        logic [31:0]       exp_last_data;
    } row_t;

    wr_t               exp_q[$];
    row_t              rows[5];
    int                n_checks = 0;
    int                n_errors = 0;
    int                wcount   = 0;
    logic [31:0]       sum_model;
    bit                first_seen;
    logic [ADDR_W-1:0] first_addr, last_addr;
    logic [31:0]       last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every mem_we must match the oldest expected word.
    wr_t mon_e;
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write addr=%h data=%h t=%0t", bus.mem_addr, bus.mem_wdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                chk("wr_data", bus.mem_wdata, mon_e.data);
            end
            wcount++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_addr = bus.mem_addr;
            end
            last_addr = bus.mem_addr;
            last_data = bus.mem_wdata;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_done",  32'(done),  32'd0);
        chk("start_error", 32'(error), 32'd0);
        chk("start_busy",  32'(busy),  32'd1);
        chk("start_seccnt", sec_cnt,   32'd0);
    endtask

    // Reader model: handshake, nbytes of pattern b_i = i[7:0], rdone, rbusy held two more cycles.
    task automatic serve(input int sec, input int nbytes, input int start_at, input int rst_at);
        bit   got;
        wr_t  e;
        int   i;
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.rstart === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("rstart_timeout", 32'd0, 32'd1);
            return;
        end
        chk("rsector", bus.rsector, START_SECTOR + 32'(sec));
        @(posedge clk); #1 bus.rbusy = 1'b1;
        for (i = 0; i < nbytes; i++) begin
            @(posedge clk); #1;
            bus.outen   = 1'b1;
            bus.outaddr = 9'(i);
            bus.outbyte = 8'(i);
            if ((i % 4) == 3 && (rst_at < 0 || i < rst_at)) begin
                e.addr = ADDR_W'(BASE_WADDR + 32'(sec) * 32'd128 + 32'(i / 4));
                e.data = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                exp_q.push_back(e);
                sum_model = sum_model + e.data;
            end
            if (start_at >= 0) begin
                if (i == start_at)     start = 1'b1;
                if (i == start_at + 1) start = 1'b0;
                if (i == start_at + 3) begin
                    chk("ign_start_busy",   32'(busy), 32'd1);
                    chk("ign_start_seccnt", sec_cnt,   32'(sec));
                end
            end
            if (rst_at >= 0) begin
                if (i == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk("midrst_busy",   32'(busy),       32'd0);
                    chk("midrst_seccnt", sec_cnt,         32'd0);
                    chk("midrst_we",     32'(bus.mem_we), 32'd0);
                    chk("midrst_rstart", 32'(bus.rstart), 32'd0);
                end
                if (i == rst_at + 2) rst   = 1'b0;
                if (i == rst_at + 4) start = 1'b1;
                if (i == rst_at + 5) start = 1'b0;
                if (i == rst_at + 8) begin
                    chk("midrst_wait_busy",   32'(busy),       32'd1);
                    chk("midrst_wait_rstart", 32'(bus.rstart), 32'd0);
                end
            end
        end
        @(posedge clk); #1 bus.outen = 1'b0; bus.rdone = 1'b1;
        @(posedge clk); #1 bus.rdone = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.rbusy = 1'b0;
    endtask

    task automatic check_load_end(input logic exp_err, input int exp_words);
        @(negedge clk);
        chk("end_done",   32'(done),    32'd1);
        chk("end_error",  32'(error),   32'(exp_err));
        chk("end_busy",   32'(busy),    32'd0);
        chk("end_seccnt", sec_cnt,      NUM_SECTORS);
        chk("end_words",  32'(wcount),  32'(exp_words));
        chk("end_queue",  32'(exp_q.size()), 32'd0);
`ifdef SD_BOOT_LOADER_CHECKSUM_EN
        chk("end_csum",   csum,         sum_model);
`endif
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog_expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{-1, 512, -1, 1'b0, 384, 16'h0100, 16'h027F, 32'hFFFEFDFC};
        rows[1] = '{ 1, 500, -1, 1'b1, 381, 16'h0100, 16'h027F, 32'hFFFEFDFC};
        rows[2] = '{-1, 512, 100, 1'b0, 384, 16'h0100, 16'h027F, 32'hFFFEFDFC};
        rows[3] = '{ 2,   6, -1, 1'b1, 257, 16'h0100, 16'h0200, 32'h03020100};
        rows[4] = '{ 0,   0, -1, 1'b1, 256, 16'h0180, 16'h027F, 32'hFFFEFDFC};

        rst = 1'b1; start = 1'b0;
        bus.rbusy = 1'b0; bus.rdone = 1'b0; bus.outen = 1'b0;
        bus.outaddr = '0; bus.outbyte = '0;
        sum_model = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",    32'(busy),          32'd0);
        chk("rst_done",    32'(done),          32'd0);
        chk("rst_error",   32'(error),         32'd0);
        chk("rst_seccnt",  sec_cnt,            32'd0);
        chk("rst_rstart",  32'(bus.rstart),    32'd0);
        chk("rst_rsector", bus.rsector,        32'd0);
        chk("rst_we",      32'(bus.mem_we),    32'd0);
        chk("rst_addr",    32'(bus.mem_addr),  32'd0);
        chk("rst_wdata",   bus.mem_wdata,      32'd0);
`ifdef SD_BOOT_LOADER_CHECKSUM_EN
        chk("rst_csum",    csum,               32'd0);
`endif
        @(posedge clk); #1 rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            wcount = 0; first_seen = 1'b0; sum_model = '0;
            pulse_start();
            for (int s = 0; s < 3; s++) begin
                serve(s, (s == rows[r].short_sec) ? rows[r].short_len : 512,
                      (s == 0) ? rows[r].start_at : -1, -1);
            end
            check_load_end(rows[r].exp_error, rows[r].exp_words);
            chk("row_first_addr", 32'(first_addr), 32'(rows[r].exp_first));
            chk("row_last_addr",  32'(last_addr),  32'(rows[r].exp_last));
            chk("row_last_data",  last_data,       rows[r].exp_last_data);
            $display("load %0d: words=%0d error=%0b sec_cnt=%0d", r, wcount, error, sec_cnt);
        end

        // Reader traffic while DONE must be ignored.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.outen = 1'b1; bus.outaddr = 9'(i | 3); bus.outbyte = 8'hA5;
            bus.rdone = (i == 5);
        end
        @(posedge clk); #1 bus.outen = 1'b0; bus.rdone = 1'b0;
        @(negedge clk);
        chk("idle_ignore_seccnt", sec_cnt,   NUM_SECTORS);
        chk("idle_ignore_done",   32'(done), 32'd1);

        // Reset part-way through sector 0 while the reader stays busy, then restart.
        wcount = 0; first_seen = 1'b0; sum_model = '0;
        pulse_start();
        serve(0, 512, -1, 201);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);
        $display("reset mid-read: stale bytes drained, writes=%0d", wcount);
        wcount = 0; first_seen = 1'b0; sum_model = '0;
        for (int s = 0; s < 3; s++) begin
            serve(s, 512, -1, -1);
        end
        check_load_end(1'b0, 384);
        chk("midrst_first_addr", 32'(first_addr), 32'h0100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
